if_stage: RTL



---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage.sv | 106 ++++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: state encodings,
// word/byte types and the PC step.
package if_stage_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [7:0]  byte_t;

  localparam addr_t      ZERO32         = 32'h0000_0000;
  localparam addr_t      PC_INC         = 32'd4;
  localparam logic [2:0] BYTES_PER_INST = 3'd4;

  localparam logic [0:0] IF_FETCH = 1'b0;
  localparam logic [0:0] IF_VALID = 1'b1;

  function automatic addr_t byte_addr(input addr_t base, input logic [2:0] idx);
    return base + {29'b0, idx};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads on
// the shared 8-bit memory port and presents it with its PC to IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_gnt_in,
  input  logic [7:0]  mem_rdata_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid_out
);

  logic [0:0] state;
  addr_t      fetch_pc;
  logic [2:0] issue_cnt;
  logic [2:0] recv_cnt;
  logic       pending;
  logic [23:0] byte_buf;

  logic  req;
  addr_t req_addr;
  logic  fire;

  // In VALID the next word's byte 0 is requested in the consuming cycle itself,
  // which is what keeps throughput at one instruction per five cycles.
  always_comb begin
    req      = 1'b0;
    req_addr = fetch_pc;
    if (state == IF_FETCH) begin
      req      = (issue_cnt < BYTES_PER_INST) && !branch_taken_in;
      req_addr = byte_addr(fetch_pc, issue_cnt);
    end else begin
      req      = !stall_in && !branch_taken_in;
      req_addr = fetch_pc + PC_INC;
    end
    fire         = req && mem_gnt_in;
    mem_req_out  = req && !rst_in;
    mem_addr_out = rst_in ? ZERO32 : req_addr;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IF_FETCH;
      fetch_pc       <= RESET_PC;
      issue_cnt      <= 3'd0;
      recv_cnt       <= 3'd0;
      pending        <= 1'b0;
      pc_out         <= ZERO32;
      inst_out       <= ZERO32;
      inst_valid_out <= 1'b0;
    end else if (branch_taken_in) begin
      state          <= IF_FETCH;
      fetch_pc       <= branch_target_in;
      issue_cnt      <= 3'd0;
      recv_cnt       <= 3'd0;
      pending        <= 1'b0;
      inst_valid_out <= 1'b0;
    end else if (state == IF_VALID) begin
      if (!stall_in) begin
        state          <= IF_FETCH;
        fetch_pc       <= fetch_pc + PC_INC;
        issue_cnt      <= fire ? 3'd1 : 3'd0;
        recv_cnt       <= 3'd0;
        pending        <= fire;
        inst_valid_out <= 1'b0;
      end
    end else begin
      pending <= fire;
      if (fire) begin
        issue_cnt <= issue_cnt + 3'd1;
      end
      if (pending) begin
        recv_cnt <= recv_cnt + 3'd1;
        if (recv_cnt == BYTES_PER_INST - 3'd1) begin
          inst_out       <= {mem_rdata_in, byte_buf};
          pc_out         <= fetch_pc;
          inst_valid_out <= 1'b1;
          state          <= IF_VALID;
        end
      end
    end
  end

  // Little-endian assembly of the first three bytes; the fourth goes straight
  // into inst_out.
  always_ff @(posedge clk_in) begin
    if (state == IF_FETCH && pending && !branch_taken_in) begin
      case (recv_cnt[1:0])
        2'd0:    byte_buf[7:0]   <= mem_rdata_in;
        2'd1:    byte_buf[15:8]  <= mem_rdata_in;
        2'd2:    byte_buf[23:16] <= mem_rdata_in;
        default: ;
      endcase
    end
  end

endmodule
